// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I instruction fetch stage feeding the opcode decoder.
// Issues in-order word reads to instruction memory under a credit limit, buffers returned words with
// their PCs in a small FIFO, and flushes wrong-path state on a PC redirect from execute.
// Build option: define IFU_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    // Fetch PC and request bookkeeping. outstanding counts every request still in flight, including
    // ones that will be discarded, so wrong-path slots keep holding their credit until they return.
    logic [31:0]      fetchPc;
    logic [31:0]      redirectAligned;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstandingNext;
    logic [CNT_W-1:0] discard;

    // Instruction buffer and the parallel queue of issued request addresses
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] tagWrPtr;
    logic [PTR_W-1:0] tagRdPtr;
    logic [CNT_W-1:0] fifoCount;
    logic [31:0]      dataArr [FIFO_DEPTH];
    logic [31:0]      pcArr   [FIFO_DEPTH];
    logic [31:0]      tagArr  [FIFO_DEPTH];
    logic [31:0]      headData;
    logic [31:0]      headPc;
    logic [31:0]      tagHead;

    logic reqFire;
    logic rspKeep;
    logic fifoPush;
    logic fifoPop;
    logic fifoEmpty;
`ifdef IFU_BYPASS_EN
    logic bypassHit;
`endif

    assign redirectAligned = redirect_pc & ~32'h0000_0003;
    assign fifoEmpty       = (fifoCount == '0);
    assign headData        = dataArr[rdPtr];
    assign headPc          = pcArr[rdPtr];
    assign tagHead         = tagArr[tagRdPtr];
    assign imem_addr       = fetchPc;

    // No request during reset or a redirect cycle; otherwise only while a buffer slot is guaranteed free
    assign imem_req_valid = rst_n && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, fifoCount}) < DEPTH_LIMIT);

    // Handshake decoding: which response is kept, when the buffer pushes/pops, next in-flight count
    always_comb begin
        reqFire = imem_req_valid && imem_req_ready;
        rspKeep = imem_rsp_valid && (discard == '0) && !redirect_valid;
        fifoPop = !fifoEmpty && instr_ready && !redirect_valid;
`ifdef IFU_BYPASS_EN
        bypassHit = fifoEmpty && rspKeep;
        fifoPush  = rspKeep && !(bypassHit && instr_ready);
`else
        fifoPush  = rspKeep;
`endif
        outstandingNext = outstanding + CNT_W'(reqFire) - CNT_W'(imem_rsp_valid);
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : gEntry
            logic [31:0] dataQ;
            logic [31:0] pcQ;
            logic [31:0] tagQ;

            // Per-entry storage: buffered word with its PC, and the address of one in-flight request
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dataQ <= '0;
                    pcQ   <= '0;
                    tagQ  <= '0;
                end else begin
                    if (fifoPush && (wrPtr == PTR_W'(gi))) begin
                        dataQ <= imem_rsp_data;
                        pcQ   <= tagHead;
                    end
                    if (reqFire && (tagWrPtr == PTR_W'(gi))) begin
                        tagQ <= fetchPc;
                    end
                end
            end

            assign dataArr[gi] = dataQ;
            assign pcArr[gi]   = pcQ;
            assign tagArr[gi]  = tagQ;
        end
    endgenerate

    // Fetch PC, in-flight/discard counters and address-tag pointers; redirect overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            tagWrPtr    <= '0;
            tagRdPtr    <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (reqFire) begin
                tagWrPtr <= tagWrPtr + PTR_W'(1);
            end
            // Every response, kept or dropped, retires the oldest issued address
            if (imem_rsp_valid) begin
                tagRdPtr <= tagRdPtr + PTR_W'(1);
            end
            if (redirect_valid) begin
                fetchPc <= redirectAligned;
                discard <= outstandingNext;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + 32'd4;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    // Instruction buffer pointers and occupancy; a redirect empties the buffer and ignores any pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else if (redirect_valid) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (fifoPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (fifoPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Decode-side view: buffer head, or the arriving word when forwarding around an empty buffer
    always_comb begin
        instr_valid = !fifoEmpty;
        instr       = headData;
        instr_pc    = headPc;
`ifdef IFU_BYPASS_EN
        if (bypassHit) begin
            instr_valid = 1'b1;
            instr       = imem_rsp_data;
            instr_pc    = tagHead;
        end
`endif
    end

    assign opcode = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit (default build).
// A bench memory answers requests in order after a random delay; a program-order model predicts the
// PC/word stream decode must see, the credit-limited request handshake and the buffer occupancy.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          issueCyc;
        bit          stale;
    } MemReq;

    MemReq       memQ[$];
    int          buffered = 0;
    logic [31:0] expPc = RESET_PC;
    logic [31:0] expFetch = RESET_PC;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          pReqReady = 100;
    int          pRsp = 100;
    int          pInstrReady = 100;
    int          handshakes = 0;

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0F0F_1357;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        memQ.delete();
        buffered = 0;
        expPc    = RESET_PC;
        expFetch = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_hold_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        $display("reset applied and released at cycle %0d", cyc);
    endtask

    // One clock cycle: drive inputs, sample mid-cycle, update the program-order model
    task automatic runCycle(input bit doRedir, input logic [31:0] rPc, input bit forceRsp);
        MemReq front;
        bit    rspNow;
        bit    hs;
        logic [31:0] w;
        imem_req_ready = ($urandom_range(99) < pReqReady);
        instr_ready    = ($urandom_range(99) < pInstrReady);
        redirect_valid = doRedir;
        redirect_pc    = rPc;
        rspNow = 1'b0;
        if (memQ.size() > 0 && memQ[0].issueCyc < cyc) begin
            rspNow = forceRsp || ($urandom_range(99) < pRsp);
        end
        imem_rsp_valid = rspNow;
        imem_rsp_data  = rspNow ? memWord(memQ[0].addr) : $urandom;
        @(negedge clk);
        check("req_valid", 32'(imem_req_valid), 32'(!doRedir && (memQ.size() + buffered < DEPTH)));
        check("instr_valid", 32'(instr_valid), 32'(buffered > 0));
        hs = instr_valid && instr_ready && !doRedir;
        if (hs) begin
            w = memWord(expPc);
            check("instr_pc", instr_pc, expPc);
            check("instr", instr, w);
            check("opcode", 32'(opcode), {25'd0, w[6:0]});
            $display("cyc %0d: decode took pc=%h instr=%h", cyc, instr_pc, instr);
            expPc = expPc + 32'd4;
            buffered--;
            handshakes++;
        end
        if (imem_req_valid && imem_req_ready) begin
            check("imem_addr", imem_addr, expFetch);
            memQ.push_back('{addr: imem_addr, issueCyc: cyc, stale: 1'b0});
            expFetch = expFetch + 32'd4;
        end
        if (rspNow) begin
            front = memQ.pop_front();
            if (!front.stale && !doRedir) begin
                buffered++;
            end
        end
        if (doRedir) begin
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            buffered = 0;
            expPc    = rPc & ~32'h3;
            expFetch = rPc & ~32'h3;
            $display("cyc %0d: redirect to %h", cyc, rPc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] tgt;
        int          hsBefore;
        #1;
        // Reset and first request address
        applyReset();
        #2;
        check("first_addr", imem_addr, RESET_PC);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_instr_valid", 32'(instr_valid), 32'd0);

        // Streaming with a one-cycle memory and an always-ready decoder
        pReqReady = 100; pRsp = 100; pInstrReady = 100;
        repeat (20) runCycle(1'b0, '0, 1'b0);
        check("stream_progress", 32'(handshakes > 8), 32'd1);

        // Decoder stalls for 6 cycles: requests must stop once credits are used
        pInstrReady = 0;
        repeat (6) runCycle(1'b0, '0, 1'b0);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        pInstrReady = 100;
        repeat (10) runCycle(1'b0, '0, 1'b0);

        // Redirect with two requests in flight: both responses dropped
        pRsp = 0;
        for (int i = 0; i < 10 && memQ.size() < 2; i++) runCycle(1'b0, '0, 1'b0);
        check("redir_setup_inflight", 32'(memQ.size()), 32'd2);
        runCycle(1'b1, 32'h0000_2002, 1'b0);
        pRsp = 100;
        hsBefore = handshakes;
        repeat (10) runCycle(1'b0, '0, 1'b0);
        check("redir_progress", 32'(handshakes > hsBefore), 32'd1);

        // Redirect near the top of the address space: PC wraps to zero
        runCycle(1'b1, 32'hFFFF_FFFC, 1'b0);
        repeat (10) runCycle(1'b0, '0, 1'b0);
        check("wrap_expPc_passed_zero", 32'(expPc < 32'h100 && expPc >= 32'h4), 32'd1);

        // Redirect coinciding with a kept response and a decode handshake
        pInstrReady = 0; pRsp = 0;
        for (int i = 0; i < 10 && (memQ.size() + buffered) < DEPTH; i++) runCycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 4 && buffered < 1; i++) runCycle(1'b0, '0, 1'b1);
        check("coinc_setup", 32'(buffered >= 1 && memQ.size() > 0 && !memQ[0].stale), 32'd1);
        pInstrReady = 100;
        runCycle(1'b1, 32'h0000_3000, 1'b1);
        pRsp = 100;
        repeat (10) runCycle(1'b0, '0, 1'b0);

        // Asynchronous reset mid-stream
        repeat (5) runCycle(1'b0, '0, 1'b0);
        applyReset();

        // Randomized traffic with random redirects
        for (int seg = 0; seg < 30; seg++) begin
            pReqReady   = $urandom_range(100, 30);
            pRsp        = $urandom_range(100, 20);
            pInstrReady = $urandom_range(100, 10);
            if (seg == 15) applyReset();
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(99) < 3) begin
                    case ($urandom_range(2))
                        0:       tgt = $urandom;
                        1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                        default: tgt = 32'h0000_1000 + 32'($urandom_range(255));
                    endcase
                    runCycle(1'b1, tgt, 1'b0);
                end else begin
                    runCycle(1'b0, '0, 1'b0);
                end
            end
        end
        check("random_progress", 32'(handshakes > 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
